// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, control bundle and pipeline-register layouts.
package pipe_pkg;
    localparam int DATA_W = 8;
    localparam int REG_ADDR_W = 3;

    typedef enum logic {IDLE, WAIT} memState_t;

    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic setFlags;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [DATA_W-1:0]     aluRes;
        logic [DATA_W-1:0]     storeData;
        logic [REG_ADDR_W-1:0] rd;
        logic                  zero;
        logic                  cOut;
    } ex_mem_t;

    typedef struct packed {
        logic                  regWrite;
        logic                  memToReg;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     aluRes;
        logic [DATA_W-1:0]     loadData;
    } mem_wb_t;
endpackage

// File: rtl/data_memory.sv
// data_memory: data RAM with asynchronous read and synchronous write, not reset.
module data_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] rData
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wData;

    assign rData = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB registers, data-memory access with wait states, zero/carry flags.
// Define CARRY_FLAG_EN to register the carry flag; otherwise carryFlag is tied low.
module mem_stage #(
    parameter int DATA_W   = pipe_pkg::DATA_W,
    parameter int ADDR_W   = 8,
    parameter int MEM_WAIT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               ALUResIn,
    input  logic [DATA_W-1:0]               writeDataIn,
    input  logic [pipe_pkg::REG_ADDR_W-1:0] RdIn,
    input  logic                            zeroIn,
    input  logic                            COutIn,
    input  logic                            regWriteIn,
    input  logic                            memReadIn,
    input  logic                            memWriteIn,
    input  logic                            memToRegIn,
    input  logic                            setFlagsIn,
    input  logic                            flushIn,
    output logic                            EX_MEM_regWrite,
    output logic [pipe_pkg::REG_ADDR_W-1:0] EX_MEM_Rd,
    output logic [DATA_W-1:0]               EX_MEM_ALURes,
    output logic                            MEM_WB_regWrite,
    output logic [pipe_pkg::REG_ADDR_W-1:0] MEM_WB_Rd,
    output logic [DATA_W-1:0]               regWriteData,
    output logic                            memBusy,
    output logic                            zeroFlag,
    output logic                            carryFlag
);
    import pipe_pkg::*;

    ex_mem_t           exMem;
    mem_wb_t           memWb;
    memState_t         state, stateNext;
    int                cnt, cntNext;
    ctrl_t             ctrlIn;
    logic              memOp, memWe;
    logic [DATA_W-1:0] loadData;

    assign memOp  = exMem.ctrl.memRead | exMem.ctrl.memWrite;
    assign memWe  = exMem.ctrl.memWrite & ~memBusy;
    assign ctrlIn = flushIn ? ctrl_t'('0) : ctrl_t'{regWriteIn, memReadIn, memWriteIn, memToRegIn, setFlagsIn};

    data_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dmem (
        .clk  (clk),
        .we   (memWe),
        .addr (exMem.aluRes[ADDR_W-1:0]),
        .wData(exMem.storeData),
        .rData(loadData)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= 0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end

    always_comb begin
        stateNext = memBusy ? WAIT : IDLE;
        cntNext   = memBusy ? cnt + 1 : 0;
    end

    // In WAIT the counter is nonzero, so IDLE alone decides the first stall cycle.
    always_comb memBusy = memOp && MEM_WAIT > 0 && (state == IDLE || cnt < MEM_WAIT);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            exMem <= '0;
            memWb <= '0;
        end else if (memBusy) begin
            memWb <= '0;
        end else begin
            exMem <= '{ctrl: ctrlIn, aluRes: ALUResIn, storeData: writeDataIn, rd: RdIn, zero: zeroIn, cOut: COutIn};
            memWb <= '{regWrite: exMem.ctrl.regWrite, memToReg: exMem.ctrl.memToReg, rd: exMem.rd,
                       aluRes: exMem.aluRes, loadData: loadData};
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) zeroFlag <= 1'b0;
        else if (!memBusy && exMem.ctrl.setFlags) zeroFlag <= exMem.zero;

`ifdef CARRY_FLAG_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) carryFlag <= 1'b0;
        else if (!memBusy && exMem.ctrl.setFlags) carryFlag <= exMem.cOut;
`else
    logic unusedCarry;
    assign unusedCarry = exMem.cOut;
    assign carryFlag   = 1'b0;
`endif

    assign EX_MEM_regWrite = exMem.ctrl.regWrite;
    assign EX_MEM_Rd       = exMem.rd;
    assign EX_MEM_ALURes   = exMem.aluRes;
    assign MEM_WB_regWrite = memWb.regWrite;
    assign MEM_WB_Rd       = memWb.rd;
    assign regWriteData    = memWb.memToReg ? memWb.loadData : memWb.aluRes;
endmodule
